// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_bht
//  Purpose  : Conditional-branch resolution unit with a 2-bit saturating
//             branch history table. It predicts from the fetch PC and resolves
//             a branch with a one-cycle registered result. It also counts
//             resolved branches and mispredictions.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_bht #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   // fetch-side prediction
   input  logic [XLEN-1:0]  p_pc,
   output logic             p_taken,
   // resolve request
   input  logic             r_valid,
   input  logic [XLEN-1:0]  r_pc,
   input  logic [2:0]       r_funct3,
   input  logic [XLEN-1:0]  r_rv1,
   input  logic [XLEN-1:0]  r_rv2,
   input  logic [XLEN-1:0]  r_imm,
   input  logic             r_pred,
   // registered resolve result
   output logic             o_valid,
   output logic             o_taken,
   output logic [XLEN-1:0]  o_next_pc,
   output logic             o_mispredict,
   output logic             o_illegal,
   output logic             o_misalign,
   // performance counters
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   // Branch type encodings carried in funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Counter reset state: weakly not-taken
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_ST  = 2'b11;
   localparam logic [1:0] CNT_SNT = 2'b00;

   logic [1:0]       bht_q [BHT_ENTRIES];

   logic             valid_q;
   logic             taken_q;
   logic [XLEN-1:0]  next_pc_q;
   logic             mispredict_q;
   logic             illegal_q;
   logic             misalign_q;
   logic [CNT_W-1:0] br_count_q;
   logic [CNT_W-1:0] mis_count_q;

   logic [IDX_W-1:0] p_idx;
   logic [IDX_W-1:0] r_idx;
   logic             cond;
   logic             legal;
   logic             taken_d;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  fallthrough;
   logic [XLEN-1:0]  next_pc_d;
   logic             mispredict_d;
   logic             misalign_d;
   logic [1:0]       cnt_cur;
   logic [1:0]       cnt_d;
   logic             unused_ok;

   // Word-aligned PC bits select the predictor entry on both ports
   assign p_idx = p_pc[IDX_W+1:2];
   assign r_idx = r_pc[IDX_W+1:2];

   // Prediction reads the stored value; a same-cycle update shows next cycle
   assign p_taken = bht_q[p_idx][1];

   // Only the index bits of the fetch PC matter to the predictor
   assign unused_ok = &{1'b0, p_pc[XLEN-1:IDX_W+2], p_pc[1:0]};

   // Evaluate branch condition, legality and next-PC candidates
   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      unique case (r_funct3)
         F3_BEQ  : cond = (r_rv1 == r_rv2);
         F3_BNE  : cond = (r_rv1 != r_rv2);
         F3_BLT  : cond = ($signed(r_rv1) <  $signed(r_rv2));
         F3_BGE  : cond = ($signed(r_rv1) >= $signed(r_rv2));
         F3_BLTU : cond = (r_rv1 <  r_rv2);
         F3_BGEU : cond = (r_rv1 >= r_rv2);
         default : legal = 1'b0;
      endcase
      taken_d      = legal & cond;
      target       = r_pc + r_imm;
      fallthrough  = r_pc + XLEN'(4);
      next_pc_d    = taken_d ? target : fallthrough;
      // Illegal encodings never count as a misprediction
      mispredict_d = legal & (taken_d ^ r_pred);
      misalign_d   = taken_d & (target[1:0] != 2'b00);
   end

   // Saturating increment/decrement of the resolved entry
   always_comb begin
      cnt_cur = bht_q[r_idx];
      cnt_d   = cnt_cur;
      if (taken_d) begin
         if (cnt_cur != CNT_ST) cnt_d = cnt_cur + 2'd1;
      end else begin
         if (cnt_cur != CNT_SNT) cnt_d = cnt_cur - 2'd1;
      end
   end

   // Predictor table: reset to WNT, updated only by legal resolves
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= CNT_WNT;
         end
      end else if (r_valid && legal) begin
         bht_q[r_idx] <= cnt_d;
      end
   end

   // Result register: flags gated by r_valid so they read 0 when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= 1'b0;
         taken_q      <= 1'b0;
         next_pc_q    <= '0;
         mispredict_q <= 1'b0;
         illegal_q    <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         valid_q      <= r_valid;
         taken_q      <= r_valid & taken_d;
         mispredict_q <= r_valid & mispredict_d;
         illegal_q    <= r_valid & ~legal;
         misalign_q   <= r_valid & misalign_d;
         // Next PC keeps its last value between results
         if (r_valid) next_pc_q <= next_pc_d;
      end
   end

   // Performance counters, wrapping naturally at their width
   always_ff @(posedge clk) begin
      if (reset) begin
         br_count_q  <= '0;
         mis_count_q <= '0;
      end else if (r_valid && legal) begin
         br_count_q  <= br_count_q + CNT_W'(1);
         mis_count_q <= mis_count_q + CNT_W'(mispredict_d);
      end
   end

   assign o_valid      = valid_q;
   assign o_taken      = taken_q;
   assign o_next_pc    = next_pc_q;
   assign o_mispredict = mispredict_q;
   assign o_illegal    = illegal_q;
   assign o_misalign   = misalign_q;
   assign br_count     = br_count_q;
   assign mis_count    = mis_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_bht
//  Purpose  : Self-checking bench for branch_resolve_bht: directed scenarios
//             plus a randomized run against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_bht;

   localparam int XLEN = 32;
   localparam int NENT = 16;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [XLEN-1:0]  p_pc;
   logic             p_taken;
   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [2:0]       r_funct3;
   logic [XLEN-1:0]  r_rv1;
   logic [XLEN-1:0]  r_rv2;
   logic [XLEN-1:0]  r_imm;
   logic             r_pred;
   logic             o_valid;
   logic             o_taken;
   logic [XLEN-1:0]  o_next_pc;
   logic             o_mispredict;
   logic             o_illegal;
   logic             o_misalign;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mis_count;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   int          m_bht [NENT];
   logic [31:0] m_npc;
   logic [31:0] m_br;
   logic [31:0] m_mis;
   logic        e_valid, e_taken, e_mis, e_ill, e_mal;

   branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .p_pc(p_pc), .p_taken(p_taken),
      .r_valid(r_valid), .r_pc(r_pc), .r_funct3(r_funct3), .r_rv1(r_rv1),
      .r_rv2(r_rv2), .r_imm(r_imm), .r_pred(r_pred),
      .o_valid(o_valid), .o_taken(o_taken), .o_next_pc(o_next_pc),
      .o_mispredict(o_mispredict), .o_illegal(o_illegal),
      .o_misalign(o_misalign), .br_count(br_count), .mis_count(mis_count)
   );

   always #5 clk = ~clk;

   // advance to 1ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [31:0] pc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic pred);
      r_valid = 1'b1; r_pc = pc; r_funct3 = f3;
      r_rv1 = a; r_rv2 = b; r_imm = imm; r_pred = pred;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      m_npc = 0; m_br = 0; m_mis = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; r_valid = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   // behavioural model of one clock edge worth of resolve
   task automatic model_apply(input logic v, input logic [31:0] pc,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm,
                              input logic pred);
      int sa, sb, idx;
      logic legal, t;
      logic [31:0] tgt;
      sa = a; sb = b;
      e_valid = v; e_taken = 0; e_mis = 0; e_ill = 0; e_mal = 0;
      if (!v) return;
      legal = 1; t = 0;
      case (f3)
         3'd0: t = (a == b);
         3'd1: t = (a != b);
         3'd4: t = (sa < sb);
         3'd5: t = !(sa < sb);
         3'd6: t = ({1'b0, a} < {1'b0, b});
         3'd7: t = !({1'b0, a} < {1'b0, b});
         default: legal = 0;
      endcase
      tgt = pc + imm;
      m_npc = t ? tgt : pc + 32'd4;
      e_taken = t;
      e_ill = !legal;
      e_mis = legal && (t != pred);
      e_mal = t && (tgt % 4 != 0);
      if (legal) begin
         idx = (pc / 4) % NENT;
         if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
         else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
         m_br = m_br + 1;
         if (e_mis) m_mis = m_mis + 1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid); else n_pass++;
      n_total++; if (o_next_pc !== 32'h0) $display("FAIL reset_npc got %h exp 0", o_next_pc); else n_pass++;
      n_total++; if ({o_taken, o_mispredict, o_illegal, o_misalign} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {o_taken, o_mispredict, o_illegal, o_misalign}); else n_pass++;
      n_total++; if (br_count !== 0 || mis_count !== 0) $display("FAIL reset_counts got %0d/%0d exp 0/0", br_count, mis_count); else n_pass++;
      for (int i = 0; i < NENT; i++) begin
         p_pc = i * 4; #1;
         n_total++; if (p_taken !== 1'b0) $display("FAIL reset_bht[%0d] got %b exp 0", i, p_taken); else n_pass++;
      end
   endtask

   task automatic test_basic_beq();
      do_reset();
      p_pc = 32'h40; #1;
      n_total++; if (p_taken !== 1'b0) $display("FAIL beq_pred_before got %b exp 0", p_taken); else n_pass++;
      set_req(32'h40, 3'b000, 32'd10, 32'd10, 32'h100, 1'b0);
      tick(); r_valid = 1'b0; #1;
      n_total++; if (o_valid !== 1'b1 || o_taken !== 1'b1) $display("FAIL beq_taken got v=%b t=%b exp 1 1", o_valid, o_taken); else n_pass++;
      n_total++; if (o_next_pc !== 32'h140) $display("FAIL beq_npc got %h exp 00000140", o_next_pc); else n_pass++;
      n_total++; if (o_mispredict !== 1'b1) $display("FAIL beq_mis got %b exp 1", o_mispredict); else n_pass++;
      n_total++; if (p_taken !== 1'b1) $display("FAIL beq_pred_after got %b exp 1", p_taken); else n_pass++;
      n_total++; if (br_count !== 1 || mis_count !== 1) $display("FAIL beq_counts got %0d/%0d exp 1/1", br_count, mis_count); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b0 || o_taken !== 1'b0 || o_mispredict !== 1'b0) $display("FAIL beq_one_cycle got v=%b t=%b m=%b exp 0 0 0", o_valid, o_taken, o_mispredict); else n_pass++;
      n_total++; if (o_next_pc !== 32'h140) $display("FAIL beq_npc_hold got %h exp 00000140", o_next_pc); else n_pass++;
   endtask

   task automatic test_compare();
      set_req(32'h200, 3'b100, 32'd10, -32'sd15, 32'h20, 1'b0);
      tick();
      n_total++; if (o_taken !== 1'b0 || o_next_pc !== 32'h204) $display("FAIL blt_signed got t=%b npc=%h exp 0 00000204", o_taken, o_next_pc); else n_pass++;
      set_req(32'h200, 3'b110, 32'd10, 32'hFFFFFFF1, 32'h20, 1'b1);
      tick();
      n_total++; if (o_taken !== 1'b1 || o_next_pc !== 32'h220 || o_mispredict !== 1'b0) $display("FAIL bltu got t=%b npc=%h m=%b exp 1 00000220 0", o_taken, o_next_pc, o_mispredict); else n_pass++;
      set_req(32'h200, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20, 1'b0);
      tick(); r_valid = 1'b0;
      n_total++; if (o_taken !== 1'b1) $display("FAIL bge_equal got %b exp 1", o_taken); else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      p_pc = 32'h80;
      set_req(32'h80, 3'b001, 32'd1, 32'd2, 32'h10, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_total++; if (o_valid !== 1'b1 || o_taken !== 1'b1) $display("FAIL sat_b2b[%0d] got v=%b t=%b exp 1 1", k, o_valid, o_taken); else n_pass++;
      end
      r_rv2 = 32'd1;              // BNE now not taken
      tick(); r_valid = 1'b0; #1;
      n_total++; if (p_taken !== 1'b1) $display("FAIL sat_st_to_wt got %b exp 1", p_taken); else n_pass++;
      r_valid = 1'b1;
      tick(); tick(); r_valid = 1'b0; #1;
      n_total++; if (p_taken !== 1'b0) $display("FAIL sat_to_snt got %b exp 0", p_taken); else n_pass++;
      n_total++; if (br_count !== 7) $display("FAIL sat_br_count got %0d exp 7", br_count); else n_pass++;
      r_rv2 = 32'd2; r_valid = 1'b1;  // one taken from SNT lands on WNT
      tick(); r_valid = 1'b0; #1;
      n_total++; if (p_taken !== 1'b0) $display("FAIL sat_snt_floor got %b exp 0", p_taken); else n_pass++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      p_pc = 32'h40;
      set_req(32'h40, 3'b000, 32'd5, 32'd5, 32'h8, 1'b0);
      #1;
      n_total++; if (p_taken !== 1'b0) $display("FAIL same_cycle_pre got %b exp 0", p_taken); else n_pass++;
      tick(); r_valid = 1'b0; #1;
      n_total++; if (p_taken !== 1'b1) $display("FAIL same_cycle_post got %b exp 1", p_taken); else n_pass++;
   endtask

   task automatic test_illegal();
      // entry 0x40 is WT after the previous scenario, counters at 1/1
      p_pc = 32'h40;
      set_req(32'h40, 3'b010, 32'd3, 32'd4, 32'h100, 1'b1);
      tick();
      n_total++; if (o_illegal !== 1'b1 || o_taken !== 1'b0 || o_mispredict !== 1'b0) $display("FAIL illegal_010 got i=%b t=%b m=%b exp 1 0 0", o_illegal, o_taken, o_mispredict); else n_pass++;
      n_total++; if (o_next_pc !== 32'h44) $display("FAIL illegal_npc got %h exp 00000044", o_next_pc); else n_pass++;
      r_funct3 = 3'b011; r_rv2 = 32'd3;
      tick(); r_valid = 1'b0; #1;
      n_total++; if (o_illegal !== 1'b1 || o_taken !== 1'b0) $display("FAIL illegal_011 got i=%b t=%b exp 1 0", o_illegal, o_taken); else n_pass++;
      n_total++; if (p_taken !== 1'b1) $display("FAIL illegal_bht got %b exp 1", p_taken); else n_pass++;
      n_total++; if (br_count !== 1 || mis_count !== 1) $display("FAIL illegal_counts got %0d/%0d exp 1/1", br_count, mis_count); else n_pass++;
      // reset wins over a simultaneous request
      set_req(32'h40, 3'b000, 32'd1, 32'd1, 32'h8, 1'b0);
      reset = 1'b1;
      tick(); reset = 1'b0; r_valid = 1'b0; #1;
      n_total++; if (o_valid !== 1'b0 || br_count !== 0 || p_taken !== 1'b0) $display("FAIL reset_prio got v=%b br=%0d p=%b exp 0 0 0", o_valid, br_count, p_taken); else n_pass++;
      model_reset();
   endtask

   task automatic test_wrap();
      set_req(32'hFFFFFFFC, 3'b000, 32'd7, 32'd7, 32'd8, 1'b1);
      tick();
      n_total++; if (o_next_pc !== 32'h4 || o_misalign !== 1'b0) $display("FAIL wrap_taken got %h mal=%b exp 00000004 0", o_next_pc, o_misalign); else n_pass++;
      r_rv2 = 32'd6;
      tick();
      n_total++; if (o_next_pc !== 32'h0 || o_taken !== 1'b0) $display("FAIL wrap_fall got %h t=%b exp 00000000 0", o_next_pc, o_taken); else n_pass++;
      r_rv2 = 32'd7; r_imm = 32'd6;
      tick(); r_valid = 1'b0;
      n_total++; if (o_misalign !== 1'b1 || o_next_pc !== 32'h2 || o_mispredict !== 1'b0) $display("FAIL misalign got mal=%b npc=%h m=%b exp 1 00000002 0", o_misalign, o_next_pc, o_mispredict); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a, b, pc, imm, x;
      logic [2:0]  f3;
      logic        v, pr;
      int          fails_here;
      do_reset();
      fails_here = 0;
      for (int it = 0; it < 400; it++) begin
         v  = ($urandom_range(0, 3) != 0);
         f3 = 3'($urandom);
         a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
         b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4);
         pc = ($urandom_range(0, 7) == 0) ? $urandom : {24'h0, 6'($urandom), 2'b00};
         x  = $urandom;
         imm = {{19{x[12]}}, x[12:1], 1'b0};
         pr = 1'($urandom);
         p_pc = ($urandom_range(0, 1) == 0) ? pc : {24'h0, 6'($urandom), 2'($urandom)};
         set_req(pc, f3, a, b, imm, pr);
         r_valid = v;
         #1;
         n_total++;
         if (p_taken !== (m_bht[(p_pc / 4) % NENT] >= 2)) begin
            $display("FAIL rand_ptaken[%0d] got %b exp %b", it, p_taken, m_bht[(p_pc / 4) % NENT] >= 2);
            fails_here++;
         end else n_pass++;
         tick();
         model_apply(v, pc, f3, a, b, imm, pr);
         n_total++;
         if ({o_valid, o_taken, o_mispredict, o_illegal, o_misalign} !== {e_valid, e_taken, e_mis, e_ill, e_mal}) begin
            $display("FAIL rand_flags[%0d] got %b exp %b", it, {o_valid, o_taken, o_mispredict, o_illegal, o_misalign}, {e_valid, e_taken, e_mis, e_ill, e_mal});
            fails_here++;
         end else n_pass++;
         n_total++;
         if (o_next_pc !== m_npc) begin
            $display("FAIL rand_npc[%0d] got %h exp %h", it, o_next_pc, m_npc);
            fails_here++;
         end else n_pass++;
         n_total++;
         if (br_count !== m_br || mis_count !== m_mis) begin
            $display("FAIL rand_counts[%0d] got %0d/%0d exp %0d/%0d", it, br_count, mis_count, m_br, m_mis);
            fails_here++;
         end else n_pass++;
         if (fails_here > 20) break;
      end
      r_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; r_valid = 1'b0; p_pc = '0; r_pc = '0; r_funct3 = '0;
      r_rv1 = '0; r_rv2 = '0; r_imm = '0; r_pred = 1'b0;
      #1;
      test_reset();
      test_basic_beq();
      test_compare();
      test_saturation();
      test_same_cycle();
      test_illegal();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16: predictor entries; power of two, >=2.
REQ-003 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port p_pc  input  XLEN  fetch PC to predict.
REQ-007 SHALL have port p_taken  output  1  combinational prediction, MSB of indexed counter.
REQ-008 SHALL have port r_valid  input  1  resolve request valid.
REQ-009 SHALL have port r_pc  input  XLEN  branch PC.
REQ-010 SHALL have port r_funct3  input  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-011 SHALL have ports r_rv1, r_rv2  input  XLEN  operands.
REQ-012 SHALL have port r_imm  input  XLEN  sign-extended B-immediate.
REQ-013 SHALL have port r_pred  input  1  prediction used at fetch.
REQ-014 SHALL have port o_valid  output  1  registered result valid.
REQ-015 SHALL have port o_taken  output  1  resolved outcome.
REQ-016 SHALL have port o_next_pc  output  XLEN  architecturally correct next PC.
REQ-017 SHALL have port o_mispredict  output  1  outcome differs from r_pred.
REQ-018 SHALL have port o_illegal  output  1  funct3 010 or 011.
REQ-019 SHALL have port o_misalign  output  1  taken target with bits[1:0] != 0.
REQ-020 SHALL have ports br_count, mis_count  output  CNT_W  resolved-branch and mispredict counts.

Function
REQ-021 SHALL index BHT with pc[log2(BHT_ENTRIES)+1:2] for both p_pc and r_pc.
REQ-022 SHALL compare equality for BEQ/BNE, signed for BLT/BGE, unsigned for BLTU/BGEU.
REQ-023 SHALL compute target = r_pc + r_imm and fallthrough = r_pc + 4, both mod 2^XLEN.
REQ-024 SHALL register results: r_valid sampled at edge N gives o_valid=1 after edge N, for one cycle only.
REQ-025 SHALL drive o_taken, o_mispredict, o_illegal, o_misalign to 0 when o_valid=0; o_next_pc holds its last value.
REQ-026 SHALL set o_next_pc = o_taken ? target : fallthrough.
REQ-027 SHALL treat illegal funct3 as not taken: o_illegal=1, o_next_pc=fallthrough, o_mispredict=0, no BHT update, no count.
REQ-028 SHALL set o_misalign when taken and target[1:0]!=0; o_next_pc still = target; mispredict computed normally.
REQ-029 SHALL keep per entry a 2-bit counter, states SNT 00, WNT 01, WT 10, ST 11.
REQ-030 SHALL on each legal resolve increment (taken) or decrement (not taken) the indexed counter, saturating at ST and SNT.
REQ-031 SHALL, when predict and update hit the same index in one cycle, return the pre-update value on p_taken; new value visible next cycle.
REQ-032 SHALL accept r_valid every cycle; consecutive updates to one entry SHALL accumulate without loss.
REQ-033 SHALL increment br_count per legal resolve and mis_count per mispredict, wrapping at 2^CNT_W.

Reset
REQ-034 SHALL on reset set all BHT entries to WNT (p_taken=0), o_valid/flags/o_next_pc to 0, both counters to 0.
REQ-035 SHALL give reset priority over r_valid in the same cycle: request dropped, no update, no count, o_valid=0 next cycle.

Verification
REQ-036 Reset; p_pc=0x40 -> p_taken=0; BEQ pc=0x40 rv1=rv2=10 imm=0x100 r_pred=0 -> next cycle o_taken=1, o_next_pc=0x140, o_mispredict=1, then p_taken=1, br_count=1, mis_count=1.
REQ-037 BLT rv1=10 rv2=-15 -> o_taken=0, o_next_pc=pc+4; BLTU rv1=10 rv2=0xFFFFFFF1 -> o_taken=1; BGE rv1=-1 rv2=-1 -> o_taken=1.
REQ-038 Saturation: 4 taken BNE at pc 0x80 back-to-back -> entry ST; 1 not-taken -> WT, p_taken=1; 2 more not-taken -> SNT, p_taken=0.
REQ-039 Same-cycle hit: p_pc=r_pc=0x40 with entry WNT and taken resolve -> p_taken=0 that cycle, 1 next cycle.
REQ-040 Illegal funct3 010 -> o_illegal=1, o_taken=0, o_next_pc=pc+4, BHT and counters unchanged; reset asserted with r_valid -> o_valid=0 next cycle.
REQ-041 Wrap/misalign: BEQ taken pc=0xFFFFFFFC imm=8 -> o_next_pc=0x00000004; not taken -> 0x00000000; taken imm=6 -> o_misalign=1.
